digit_entry_buffer: RTL and testbench

//  Parametrised keypad number-entry buffer, the successor of the fixed 5-digit input stage.

---
 rtl/digit_entry_buffer_if.sv | 20 ++
 rtl/digit_entry_buffer.sv | 132 +++++++++++++
 tb/tb_digit_entry_buffer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/digit_entry_buffer_if.sv
// rtl/digit_entry_buffer_if.sv - converted-operand valid/ready handshake between entry buffer and core
interface digit_entry_buffer_if #(
  parameter int VALUE_W = 18
);
  logic [VALUE_W-1:0] value_o;
  logic               value_valid;
  logic               value_ready;

  modport master (
    output value_o,
    output value_valid,
    input  value_ready
  );

  modport slave (
    input  value_o,
    input  value_valid,
    output value_ready
  );
endinterface

// File: rtl/digit_entry_buffer.sv
// rtl/digit_entry_buffer.sv - keypad signed decimal entry buffer with serial BCD-to-binary conversion
module digit_entry_buffer #(
  parameter int NUM_DIGITS = 5,
  parameter int VALUE_W    = 18,
  parameter int KEY_W      = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [KEY_W-1:0]                key_pulse,
  output logic [NUM_DIGITS*4-1:0]         digits_o,
  output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count,
  output logic                            neg_o,
  output logic                            full_o,
  output logic                            busy_o,
  digit_entry_buffer_if.master            out_if
);
  localparam int DW = NUM_DIGITS * 4;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {ENTRY, CONVERT, HOLD} state_t;

  state_t             state;
  logic [DW-1:0]      digits;
  logic [CW-1:0]      count;
  logic               neg;
  logic [VALUE_W-1:0] acc;
  logic [IW-1:0]      idx;
  logic               fin;
  logic [VALUE_W-1:0] value_r;
  logic               valid_r;

  logic               k_clear, k_enter, k_back, k_sign;
  logic               dig_hit;
  logic [3:0]         dig_val;
  logic [3:0]         cur_digit;
  logic               unused_keys;

  assign k_clear     = key_pulse[12];
  assign k_enter     = key_pulse[13];
  assign k_back      = key_pulse[11];
  assign k_sign      = key_pulse[10];
  assign unused_keys = ^key_pulse;

  // Descending scan so the lowest asserted digit key wins.
  always_comb begin
    dig_hit = 1'b0;
    dig_val = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (key_pulse[i]) begin
        dig_hit = 1'b1;
        dig_val = 4'(i);
      end
    end
  end

  assign cur_digit = 4'(digits >> (4 * idx));

  assign digits_o           = digits;
  assign digit_count        = count;
  assign neg_o              = neg;
  assign full_o             = (count == CW'(NUM_DIGITS));
  assign busy_o             = (state != ENTRY);
  assign out_if.value_o     = value_r;
  assign out_if.value_valid = valid_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ENTRY;
      digits  <= '0;
      count   <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      idx     <= '0;
      fin     <= 1'b0;
      value_r <= '0;
      valid_r <= 1'b0;
    end else begin
      case (state)
        ENTRY: begin
          if (k_clear) begin
            digits <= '0;
            count  <= '0;
            neg    <= 1'b0;
          end else if (k_enter) begin
            acc   <= '0;
            idx   <= IW'(NUM_DIGITS - 1);
            fin   <= 1'b0;
            state <= CONVERT;
          end else if (k_back) begin
            if (count != '0) begin
              digits <= digits >> 4;
              count  <= count - 1'b1;
            end
          end else if (k_sign) begin
            neg <= ~neg;
          end else if (dig_hit && !full_o && !(count == '0 && dig_val == 4'd0)) begin
            digits <= (digits << 4) | DW'(dig_val);
            count  <= count + 1'b1;
          end
        end
        CONVERT: begin
          if (k_clear) begin
            digits <= '0;
            count  <= '0;
            neg    <= 1'b0;
            state  <= ENTRY;
          end else if (fin) begin
            // Unsigned negate also maps -0 to 0.
            value_r <= neg ? -acc : acc;
            valid_r <= 1'b1;
            state   <= HOLD;
          end else begin
            acc <= acc * VALUE_W'(10) + VALUE_W'(cur_digit);
            if (idx == '0) fin <= 1'b1;
            else           idx <= idx - 1'b1;
          end
        end
        HOLD: begin
          if (k_clear || out_if.value_ready) begin
            valid_r <= 1'b0;
            digits  <= '0;
            count   <= '0;
            neg     <= 1'b0;
            state   <= ENTRY;
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end
endmodule

// File: tb/tb_digit_entry_buffer.sv
// tb/tb_digit_entry_buffer.sv - directed self-checking bench for digit_entry_buffer
module tb_digit_entry_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] key_pulse;
  logic [19:0] digits_o;
  logic [2:0]  digit_count;
  logic        neg_o, full_o, busy_o;
  int          checks = 0;
  int          errors = 0;

  digit_entry_buffer_if #(.VALUE_W(18)) vif ();

  digit_entry_buffer #(.NUM_DIGITS(5), .VALUE_W(18), .KEY_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_pulse  (key_pulse),
    .digits_o   (digits_o),
    .digit_count(digit_count),
    .neg_o      (neg_o),
    .full_o     (full_o),
    .busy_o     (busy_o),
    .out_if     (vif)
  );

  always #5 clk = ~clk;

  task automatic press(input int k);
    @(negedge clk) key_pulse = 16'(1) << k;
    @(negedge clk) key_pulse = '0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (vif.value_valid !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; key_pulse = '0; vif.value_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({digits_o, digit_count, neg_o, busy_o, vif.value_valid} !== 25'd0 || vif.value_o !== 18'd0) begin
      errors++;
      $display("FAIL reset: digits=%h cnt=%0d neg=%b busy=%b valid=%b value=%h, required all 0",
               digits_o, digit_count, neg_o, busy_o, vif.value_valid, vif.value_o);
    end
    reset = 1'b0;
  endtask

  task automatic test_full_entry;
    int n;
    vif.value_ready = 1'b1;
    for (int d = 1; d <= 5; d++) press(d);
    checks++;
    if (digits_o !== 20'h12345 || full_o !== 1'b1 || digit_count !== 3'd5) begin
      errors++;
      $display("FAIL entry12345: digits=%h full=%b cnt=%0d, required 12345 1 5", digits_o, full_o, digit_count);
    end
    press(13);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_enter: busy=%b, required 1", busy_o);
    end
    wait_valid(n);
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL latency: %0d cycles, required 6", n);
    end
    checks++;
    if (vif.value_o !== 18'd12345) begin
      errors++;
      $display("FAIL value12345: value=%0d, required 12345", vif.value_o);
    end
    @(negedge clk);
    checks++;
    if (vif.value_valid !== 1'b0 || digit_count !== 3'd0 || digits_o !== 20'h0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL handshake_clear: valid=%b cnt=%0d digits=%h busy=%b, required 0 0 0 0",
               vif.value_valid, digit_count, digits_o, busy_o);
    end
  endtask

  task automatic test_negative;
    int n;
    press(0); press(0); press(7); press(10);
    checks++;
    if (digit_count !== 3'd1 || digits_o !== 20'h00007 || neg_o !== 1'b1) begin
      errors++;
      $display("FAIL leading_zero_sign: cnt=%0d digits=%h neg=%b, required 1 00007 1", digit_count, digits_o, neg_o);
    end
    press(13);
    wait_valid(n);
    checks++;
    if (vif.value_o !== 18'h3FFF9) begin
      errors++;
      $display("FAIL value_minus7: value=%h, required 3fff9", vif.value_o);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow_backspace;
    int n;
    for (int i = 0; i < 6; i++) press(9);
    checks++;
    if (digits_o !== 20'h99999 || digit_count !== 3'd5) begin
      errors++;
      $display("FAIL sixth_digit: digits=%h cnt=%0d, required 99999 5", digits_o, digit_count);
    end
    press(11);
    checks++;
    if (digits_o !== 20'h09999 || digit_count !== 3'd4 || full_o !== 1'b0) begin
      errors++;
      $display("FAIL backspace: digits=%h cnt=%0d full=%b, required 09999 4 0", digits_o, digit_count, full_o);
    end
    press(13);
    wait_valid(n);
    checks++;
    if (vif.value_o !== 18'd9999) begin
      errors++;
      $display("FAIL value9999: value=%0d, required 9999", vif.value_o);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_and_priority;
    int n;
    press(10); press(13);
    wait_valid(n);
    checks++;
    if (vif.value_o !== 18'd0 || n > 6) begin
      errors++;
      $display("FAIL neg_zero: value=%h cycles=%0d, required 0 within 6", vif.value_o, n);
    end
    @(negedge clk);
    press(5);
    @(negedge clk) key_pulse = 16'h1004;
    @(negedge clk) key_pulse = '0;
    checks++;
    if (digits_o !== 20'h0 || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL clear_priority: digits=%h cnt=%0d, required 0 0", digits_o, digit_count);
    end
  endtask

  task automatic test_backpressure;
    int n;
    vif.value_ready = 1'b0;
    press(4); press(2); press(13);
    wait_valid(n);
    for (int i = 0; i < 5; i++) press(3);
    checks++;
    if (vif.value_valid !== 1'b1 || vif.value_o !== 18'd42 || digits_o !== 20'h00042 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL hold: valid=%b value=%0d digits=%h busy=%b, required 1 42 00042 1",
               vif.value_valid, vif.value_o, digits_o, busy_o);
    end
    vif.value_ready = 1'b1;
    @(negedge clk);
    vif.value_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (vif.value_valid !== 1'b0 || busy_o !== 1'b0 || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL single_transfer: valid=%b busy=%b cnt=%0d, required 0 0 0", vif.value_valid, busy_o, digit_count);
    end
  endtask

  task automatic test_abort;
    int n;
    press(1); press(2); press(3); press(13);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (vif.value_o !== 18'd0 || vif.value_valid !== 1'b0 || busy_o !== 1'b0 || digits_o !== 20'h0) begin
      errors++;
      $display("FAIL reset_convert: value=%0d valid=%b busy=%b digits=%h, required 0 0 0 0",
               vif.value_o, vif.value_valid, busy_o, digits_o);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (vif.value_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_stale_valid: valid=%b, required 0", vif.value_valid);
    end
    press(8); press(13);
    wait_valid(n);
    press(12);
    checks++;
    if (vif.value_valid !== 1'b0 || busy_o !== 1'b0 || digits_o !== 20'h0 || vif.value_o !== 18'd8) begin
      errors++;
      $display("FAIL clear_hold: valid=%b busy=%b digits=%h value=%0d, required 0 0 0 8",
               vif.value_valid, busy_o, digits_o, vif.value_o);
    end
  endtask

  initial begin
    test_reset();
    test_full_entry();
    test_negative();
    test_overflow_backspace();
    test_zero_and_priority();
    test_backpressure();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
